// File: rtl/seq_player.sv
// Sequence playback engine: walks the sequence memory from address 0 up to the
// latched round length. Each colour is lit one-hot for a speed-dependent ON window
// and then followed by a dark OFF gap. A start/busy/done handshake connects it to
// the game FSM.
module seq_player #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned BASE_ON  = 25
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic [ADDR_W:0]   round,
  input  logic [7:0]        setup,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MAX_CYC = BASE_ON * 4 * TICK_DIV;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     index_q, index_d;
  logic [ADDR_W:0]     round_q, round_d;
  logic [1:0]          speed_q, speed_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          led_q, led_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]     idx_inc;

  // setup[5:0] carries other game options that do not affect playback
  logic unused_setup;
  assign unused_setup = ^setup[5:0];

  // Counter reload value for the ON window: BASE_ON*(4-speed) ticks, minus one
  function automatic logic [CNT_W-1:0] on_load(input logic [1:0] sp);
    int unsigned ticks;
    ticks = BASE_ON * (32'd4 - 32'(sp));
    return CNT_W'(ticks * TICK_DIV - 32'd1);
  endfunction

  // Counter reload value for the OFF gap: half the ON ticks, at least one tick
  function automatic logic [CNT_W-1:0] off_load(input logic [1:0] sp);
    int unsigned ticks;
    ticks = (BASE_ON * (32'd4 - 32'(sp))) / 32'd2;
    if (ticks == 32'd0) ticks = 32'd1;
    return CNT_W'(ticks * TICK_DIV - 32'd1);
  endfunction

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    round_d   = round_q;
    speed_d   = speed_q;
    cnt_d     = cnt_q;
    led_d     = led_q;
    rd_addr_d = rd_addr_q;
    idx_inc   = index_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        led_d = '0;
        if (start) begin
          round_d = round;
          speed_d = setup[7:6];
          index_d = '0;
          if (round == '0) begin
            state_d = S_DONE;
          end else begin
            // Address is loaded on entry to FETCH so memory data is back by WAIT exit
            rd_addr_d = '0;
            state_d   = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        led_d   = 4'b0001 << rd_data;
        cnt_d   = on_load(speed_q);
        state_d = S_ON;
      end
      S_ON: begin
        if (cnt_q == '0) begin
          led_d   = '0;
          cnt_d   = off_load(speed_q);
          state_d = S_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_OFF: begin
        if (cnt_q == '0) begin
          index_d = idx_inc;
          if (idx_inc == round_q) begin
            state_d = S_DONE;
          end else begin
            rd_addr_d = idx_inc[ADDR_W-1:0];
            state_d   = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        led_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        led_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      round_q   <= '0;
      speed_q   <= '0;
      cnt_q     <= '0;
      led_q     <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      round_q   <= round_d;
      speed_q   <= speed_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign led     = led_q;
  assign rd_addr = rd_addr_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule

// File: doc/seq_player.md
Name: seq_player

Overview:
- Plays the current Genius colour sequence back to the player. It runs after setup has been captured and before player input is accepted.
- Speed comes from the game setup byte. Colours are read one entry at a time from the sequence memory; each is lit on a one-hot LED bus for a timed ON window, followed by a dark OFF gap.
- Start/busy/done handshake to the game FSM.

Parameters:
- ADDR_W, 4, sequence memory address width; maximum round = 2**ADDR_W.
- TICK_DIV, 500000, clk cycles per timing tick (100 Hz at 50 MHz).
- BASE_ON, 25, ON duration in ticks at the fastest speed.

Ports:
- clk  in  1  system clock, rising edge.
- R  in  1  reset, asynchronous, active-low; R=0 forces reset state.
- start  in  1  one-cycle request to play the current round; sampled only in IDLE.
- round  in  ADDR_W+1  number of entries to play, 0..2**ADDR_W.
- setup  in  8  game setup byte; setup[7:6] = speed (00 slowest .. 11 fastest); setup[5:0] ignored.
- rd_addr  out  ADDR_W  sequence memory read address.
- rd_data  in  2  colour code returned by the memory one cycle after rd_addr.
- led  out  4  one-hot colour display; code k lights led[k].
- busy  out  1  high from the cycle after start is accepted until the DONE cycle inclusive.
- done  out  1  one-cycle pulse when playback completes.

Behaviour:
- Reset (R=0, async):
  - State = IDLE.
  - led, rd_addr, busy, done, index and cycle counter all 0.
  - Reset mid-playback aborts immediately. No done pulse is issued.
- Start: on the start edge in IDLE, latch round and setup[7:6] into internal registers. Later changes on round/setup have no effect until the next start.
- Timing:
  - on_ticks = BASE_ON*(4-speed). off_ticks = on_ticks/2, truncated, minimum 1.
  - ON lasts exactly on_ticks*TICK_DIV cycles; OFF lasts exactly off_ticks*TICK_DIV cycles.
  - The counter is loaded on state entry, so there is no prescaler phase error.
- States:
  - IDLE: busy=0, led=0. start=1 -> FETCH with index=0. If the latched round=0, go to DONE instead.
  - FETCH (1 cycle): rd_addr=index registered -> WAIT.
  - WAIT (1 cycle): memory latency. On exit, capture rd_data and decode it into led -> ON.
  - ON: led held one-hot for the ON duration -> OFF.
  - OFF: led=0 for the OFF duration. On exit, index+1. If index+1 == latched round -> DONE, else -> FETCH.
  - DONE (1 cycle): done=1, busy=1, led=0 -> IDLE.
- Per-entry period is 2 + ON + OFF cycles. The first LED rises 3 cycles after the start cycle.
- start while busy is ignored: it causes no restart and is not queued.
- start in the same cycle as DONE is ignored. It is accepted from the following IDLE cycle.
- round = 2**ADDR_W plays every address 0..2**ADDR_W-1. index is ADDR_W+1 bits wide, so it does not wrap early.
- led never has more than one bit set; it is 0 in every state except ON.
- rd_addr holds its last value outside FETCH.

Test Plan (TICK_DIV=2, BASE_ON=2, ADDR_W=2):
- Reset: R=0 while in ON -> led=0, busy=0, done=0 asynchronously. After R=1, the FSM sits in IDLE until a start.
- Single entry, speed=11:
  - Stimulus: round=1, memory[0]=2'b10, start pulse.
  - Required: busy rises next cycle. led=4'b0100 for exactly 4 cycles starting 3 cycles after start, then led=0 for 2 cycles. done pulses once, with busy=1 on that cycle.
- Full round, speed=00:
  - Stimulus: round=4, memory={0,1,2,3}.
  - Required: led shows 0001, 0010, 0100, 1000 in that order. Each ON lasts 16 cycles; each OFF lasts 8 cycles. rd_addr steps 0..3. One done pulse.
- round=0: start -> busy for exactly 1 cycle (DONE), done pulses, led stays 0, no rd_addr change.
- Ignored inputs: start re-pulsed, and setup/round changed, mid-playback -> timing and length unchanged from the latched values. No second done pulse.
- Back-to-back: start asserted in the DONE cycle is ignored. Start asserted one cycle later launches a new playback.
